// File: rtl/ghostchip_pkg.sv
// ghostchip_pkg: shared constants and types for the pixel-memory arbiter.
//   OP_*         : CPU operation codes carried on cpu_op
//   VRAM_W/H     : pixel memory geometry (columns x rows)
//   PIX_W        : bits per pixel (two bitplanes)
//   vram_state_t : arbiter/sequencer states
package ghostchip_pkg;

  localparam int VRAM_W = 128;
  localparam int VRAM_H = 64;
  localparam int PIX_W  = 2;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,      // waiting for a request
    RD_ADDR,   // read address on the memory port
    RD_DATA,   // mem_rdata captured at the end of this cycle
    XOR_WR,    // single write cycle (plain write or xor write-back)
    CLEAR,     // walking the screen writing zeros
    CLR_DISP   // display read slotted into a paused clear
  } vram_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU, display and memory-port signals of the arbiter.
//   cpu_*  : CPU request/ack with op, address, data, read-back and collision
//   disp_* : display scan read request and returned pixel
//   mem_*  : single-port pixel memory address/write/read-data
//   busy   : arbiter is mid-operation
// slave modport is the arbiter side; master is the requester/memory side.
interface vram_arbiter_if #(
  parameter int HW = 7,
  parameter int VW = 6,
  parameter int PW = 2
);
  logic          cpu_req;
  logic [1:0]    cpu_op;
  logic [HW-1:0] cpu_hpos;
  logic [VW-1:0] cpu_vpos;
  logic [PW-1:0] cpu_pixel;
  logic          cpu_ack;
  logic [PW-1:0] cpu_rdata;
  logic          cpu_collide;
  logic          disp_req;
  logic [HW-1:0] disp_hpos;
  logic [VW-1:0] disp_vpos;
  logic          disp_valid;
  logic [PW-1:0] disp_pixel;
  logic [HW-1:0] mem_hpos;
  logic [VW-1:0] mem_vpos;
  logic          mem_we;
  logic [PW-1:0] mem_wdata;
  logic [PW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  cpu_req, cpu_op, cpu_hpos, cpu_vpos, cpu_pixel,
    input  disp_req, disp_hpos, disp_vpos, mem_rdata,
    output cpu_ack, cpu_rdata, cpu_collide, disp_valid, disp_pixel,
    output mem_hpos, mem_vpos, mem_we, mem_wdata, busy
  );

  modport master (
    output cpu_req, cpu_op, cpu_hpos, cpu_vpos, cpu_pixel,
    output disp_req, disp_hpos, disp_vpos, mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_collide, disp_valid, disp_pixel,
    input  mem_hpos, mem_vpos, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/vram_clear_ctr.sv
// vram_clear_ctr: row-major screen address walker used by the clear op.
//   start    : load (0,0)
//   advance  : step to the next address (column fastest), no wrap
//   done     : current address is the last one (all ones in both fields)
//   nxt_*    : address the counter moves to on advance
module vram_clear_ctr #(
  parameter int HW = 7,
  parameter int VW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          advance,
  output logic          done,
  output logic [HW-1:0] nxt_hpos,
  output logic [VW-1:0] nxt_vpos
);
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;

  assign done = (&hpos) && (&vpos);

  always_comb begin
    nxt_hpos = hpos + HW'(1);
    nxt_vpos = vpos;
    if (&hpos) begin
      nxt_hpos = '0;
      nxt_vpos = vpos + VW'(1);
    end
    // parked on the last address
    if (done) begin
      nxt_hpos = hpos;
      nxt_vpos = vpos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      hpos <= '0;
      vpos <= '0;
    end else if (advance) begin
      hpos <= nxt_hpos;
      vpos <= nxt_vpos;
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port pixel memory between CPU operations
// (read, write, xor-draw, full clear) and display scan reads.
//   clk, rst : clock and synchronous active-high reset
//   bus      : vram_arbiter_if slave (cpu_*, disp_*, mem_*, busy)
// One access outstanding at a time; round-robin on simultaneous requests;
// the display may interleave single reads into a running clear.
module vram_arbiter
  import ghostchip_pkg::*;
#(
  parameter int HW = 7,
  parameter int VW = 6,
  parameter int PW = 2
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);
  vram_state_t   st, st_d;
  logic [1:0]    ph, ph_d;
  logic          last_disp, last_disp_d;  // 1: display won the last grant
  logic          src_disp, src_disp_d;    // current read belongs to display
  logic [1:0]    op_q, op_d;
  logic [PW-1:0] pix_q, pix_d, old_q, old_d;
  logic [HW-1:0] mh_q, mh_d;
  logic [VW-1:0] mv_q, mv_d;
  logic          we_q, we_d;
  logic [PW-1:0] wd_q, wd_d, rd_q, rd_d, dp_q, dp_d;
  logic          ack_q, ack_d, col_q, col_d, dv_q, dv_d, busy_q;
  logic          gnt_disp, ctr_start, ctr_adv, ctr_done;
  logic [HW-1:0] ctr_nh;
  logic [VW-1:0] ctr_nv;

  vram_clear_ctr #(.HW(HW), .VW(VW)) u_clr (
    .clk(clk), .rst(rst), .start(ctr_start), .advance(ctr_adv),
    .done(ctr_done), .nxt_hpos(ctr_nh), .nxt_vpos(ctr_nv)
  );

  always_comb begin
    st_d = st; ph_d = ph; last_disp_d = last_disp; src_disp_d = src_disp;
    op_d = op_q; pix_d = pix_q; old_d = old_q;
    mh_d = mh_q; mv_d = mv_q; we_d = 1'b0; wd_d = wd_q;
    ack_d = 1'b0; dv_d = 1'b0; col_d = col_q; rd_d = rd_q; dp_d = dp_q;
    gnt_disp = 1'b0; ctr_start = 1'b0; ctr_adv = 1'b0;
    unique case (st)
      IDLE: if (bus.cpu_req || bus.disp_req) begin
        // on conflict the side that did not win last time goes first
        gnt_disp    = bus.disp_req && (!bus.cpu_req || !last_disp);
        last_disp_d = gnt_disp;
        src_disp_d  = gnt_disp;
        if (gnt_disp) begin
          mh_d = bus.disp_hpos; mv_d = bus.disp_vpos;
          st_d = RD_ADDR;
        end else begin
          op_d = bus.cpu_op; pix_d = bus.cpu_pixel;
          mh_d = bus.cpu_hpos; mv_d = bus.cpu_vpos;
          unique case (bus.cpu_op)
            OP_WR:   begin st_d = XOR_WR; we_d = 1'b1; wd_d = bus.cpu_pixel; end
            OP_CLR:  begin
              st_d = CLEAR; ctr_start = 1'b1; we_d = 1'b1; wd_d = '0;
              mh_d = '0; mv_d = '0;
            end
            default: st_d = RD_ADDR;
          endcase
        end
      end
      RD_ADDR: st_d = RD_DATA;
      RD_DATA: begin
        st_d = IDLE;
        if (src_disp) begin
          dp_d = bus.mem_rdata; dv_d = 1'b1;
        end else if (op_q == OP_XOR) begin
          // old value is held internally so outputs only move on ack
          old_d = bus.mem_rdata; we_d = 1'b1; wd_d = bus.mem_rdata ^ pix_q;
          st_d = XOR_WR;
        end else begin
          rd_d = bus.mem_rdata; col_d = 1'b0; ack_d = 1'b1;
        end
      end
      XOR_WR: begin
        st_d = IDLE; ack_d = 1'b1; col_d = 1'b0;
        if (op_q == OP_XOR) begin
          rd_d  = old_q;
          col_d = |(old_q & pix_q);
        end
      end
      CLEAR: begin
        if (ctr_done) begin
          st_d = IDLE; ack_d = 1'b1; col_d = 1'b0;
        end else if (bus.disp_req) begin
          // counter holds the address just written; resume advances it
          st_d = CLR_DISP; ph_d = 2'd0;
          mh_d = bus.disp_hpos; mv_d = bus.disp_vpos;
        end else begin
          ctr_adv = 1'b1; mh_d = ctr_nh; mv_d = ctr_nv; we_d = 1'b1; wd_d = '0;
        end
      end
      CLR_DISP: begin
        // phase 0: address out, 1: data captured, 2: valid pulse then resume
        ph_d = ph + 2'd1;
        if (ph == 2'd1) begin
          dp_d = bus.mem_rdata; dv_d = 1'b1;
        end else if (ph == 2'd2) begin
          st_d = CLEAR; ctr_adv = 1'b1;
          mh_d = ctr_nh; mv_d = ctr_nv; we_d = 1'b1; wd_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE; ph <= '0; last_disp <= 1'b1; src_disp <= 1'b0;
      op_q <= '0; pix_q <= '0; old_q <= '0;
      mh_q <= '0; mv_q <= '0; we_q <= 1'b0; wd_q <= '0;
      ack_q <= 1'b0; dv_q <= 1'b0; col_q <= 1'b0; rd_q <= '0; dp_q <= '0;
      busy_q <= 1'b0;
    end else begin
      st <= st_d; ph <= ph_d; last_disp <= last_disp_d; src_disp <= src_disp_d;
      op_q <= op_d; pix_q <= pix_d; old_q <= old_d;
      mh_q <= mh_d; mv_q <= mv_d; we_q <= we_d; wd_q <= wd_d;
      ack_q <= ack_d; dv_q <= dv_d; col_q <= col_d; rd_q <= rd_d; dp_q <= dp_d;
      // covers the ack/valid cycle, where the state is already back in IDLE
      busy_q <= (st != IDLE) || (st_d != IDLE);
    end
  end

  assign bus.cpu_ack     = ack_q;
  assign bus.cpu_rdata   = rd_q;
  assign bus.cpu_collide = col_q;
  assign bus.disp_valid  = dv_q;
  assign bus.disp_pixel  = dp_q;
  assign bus.mem_hpos    = mh_q;
  assign bus.mem_vpos    = mv_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_wdata   = wd_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized self-checking bench for vram_arbiter.
// A behavioural memory sits on the mem_* port; a separate shadow array plus
// a round-robin flag model what every transaction should return and when.
module tb_vram_arbiter;
  import ghostchip_pkg::*;
  localparam int HW = 7, VW = 6, PW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   mem_init = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.HW(HW), .VW(VW), .PW(PW)) bus ();
  vram_arbiter #(.HW(HW), .VW(VW), .PW(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [PW-1:0] vmem    [VRAM_H][VRAM_W];
  logic [PW-1:0] ref_mem [VRAM_H][VRAM_W];
  int nvec = 0, nerr = 0;
  bit ref_last_disp;

  function automatic logic [1:0] pat(int h, int v);
    return 2'((h * 5) ^ (v * 3) ^ (h >> 3));
  endfunction

  // single-port synchronous memory: read data one cycle after the address
  always @(posedge clk) begin
    if (mem_init) begin
      for (int v = 0; v < VRAM_H; v++)
        for (int h = 0; h < VRAM_W; h++) vmem[v][h] <= pat(h, v);
    end else if (bus.mem_we) begin
      vmem[bus.mem_vpos][bus.mem_hpos] <= bus.mem_wdata;
    end
    bus.mem_rdata <= vmem[bus.mem_vpos][bus.mem_hpos];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_do(input logic [1:0] op, input int h, input int v, input logic [1:0] pix);
    int lat, we_lat, nwe;
    logic [1:0] old, wd;
    logic [6:0] wh;
    logic [5:0] wv;
    bit got, bsy;
    old = ref_mem[v][h]; lat = 0; we_lat = -1; nwe = 0; got = 0; bsy = 0;
    wd = '0; wh = '0; wv = '0;
    bus.cpu_op = op; bus.cpu_hpos = 7'(h); bus.cpu_vpos = 6'(v); bus.cpu_pixel = pix;
    bus.cpu_req = 1'b1;
    while (!got && lat < 20) begin
      tick; lat++;
      if (bus.mem_we) begin
        nwe++; we_lat = lat; wd = bus.mem_wdata; wh = bus.mem_hpos; wv = bus.mem_vpos;
      end
      if (bus.cpu_ack) begin got = 1; bsy = bus.busy; end
    end
    bus.cpu_req = 1'b0;
    ref_last_disp = 1'b0;
    case (op)
      OP_RD: begin
        chk("rd_lat", lat, 3); chk("rd_data", bus.cpu_rdata, old);
        chk("rd_col", bus.cpu_collide, 0); chk("rd_nwe", nwe, 0);
      end
      OP_WR: begin
        chk("wr_lat", lat, 2); chk("wr_we_cyc", we_lat, 1); chk("wr_nwe", nwe, 1);
        chk("wr_wdata", wd, pix); chk("wr_addr", {wh, wv}, {7'(h), 6'(v)});
        chk("wr_col", bus.cpu_collide, 0);
        ref_mem[v][h] = pix;
      end
      default: begin
        chk("xor_lat", lat, 4); chk("xor_we_cyc", we_lat, 3); chk("xor_nwe", nwe, 1);
        chk("xor_wdata", wd, old ^ pix); chk("xor_addr", {wh, wv}, {7'(h), 6'(v)});
        chk("xor_old", bus.cpu_rdata, old);
        chk("xor_col", bus.cpu_collide, (old & pix) != 2'b00);
        ref_mem[v][h] = old ^ pix;
      end
    endcase
    chk("ack_busy", bsy, 1);
  endtask

  task automatic disp_do(input int h, input int v);
    int lat, nwe;
    bit got;
    lat = 0; nwe = 0; got = 0;
    bus.disp_hpos = 7'(h); bus.disp_vpos = 6'(v); bus.disp_req = 1'b1;
    while (!got && lat < 20) begin
      tick; lat++;
      if (bus.mem_we) nwe++;
      if (bus.disp_valid) got = 1;
    end
    bus.disp_req = 1'b0;
    ref_last_disp = 1'b1;
    chk("disp_lat", lat, 3); chk("disp_pix", bus.disp_pixel, ref_mem[v][h]);
    chk("disp_nwe", nwe, 0);
  endtask

  // both sides request in the same cycle; cpu side is a read
  task automatic both_do(input int ch, input int cv, input int dh, input int dv);
    int lat, clat, dlat;
    logic [1:0] cd, dd;
    bit disp_first;
    disp_first = !ref_last_disp;
    lat = 0; clat = -1; dlat = -1; cd = '0; dd = '0;
    bus.cpu_op = OP_RD; bus.cpu_hpos = 7'(ch); bus.cpu_vpos = 6'(cv);
    bus.disp_hpos = 7'(dh); bus.disp_vpos = 6'(dv);
    bus.cpu_req = 1'b1; bus.disp_req = 1'b1;
    while ((clat < 0 || dlat < 0) && lat < 30) begin
      tick; lat++;
      if (bus.cpu_ack)    begin clat = lat; cd = bus.cpu_rdata;  bus.cpu_req = 1'b0;  end
      if (bus.disp_valid) begin dlat = lat; dd = bus.disp_pixel; bus.disp_req = 1'b0; end
    end
    bus.cpu_req = 1'b0; bus.disp_req = 1'b0;
    chk("rr_cpu_lat", clat, disp_first ? 6 : 3);
    chk("rr_disp_lat", dlat, disp_first ? 3 : 6);
    chk("rr_cpu_data", cd, ref_mem[cv][ch]);
    chk("rr_disp_data", dd, ref_mem[dv][dh]);
    ref_last_disp = !disp_first;
  endtask

  // disp_at > 0: raise one display request in cycle G+disp_at
  task automatic clear_do(input int disp_at, input int dh, input int dv);
    int lat, nwe, nbad, vlat;
    logic [12:0] first_a, last_a;
    logic [1:0] vpix, vexp;
    bit got;
    lat = 0; nwe = 0; nbad = 0; vlat = -1; got = 0; vpix = 2'b11;
    first_a = '1; last_a = '0;
    // addresses written so far lie before index disp_at in scan order
    vexp = (dv * VRAM_W + dh < disp_at) ? 2'b00 : ref_mem[dv][dh];
    bus.cpu_op = OP_CLR; bus.cpu_req = 1'b1;
    while (!got && lat < 9000) begin
      tick; lat++;
      if (bus.mem_we) begin
        if (nwe == 0) first_a = {bus.mem_hpos, bus.mem_vpos};
        last_a = {bus.mem_hpos, bus.mem_vpos};
        nwe++;
        if (bus.mem_wdata != 2'b00) nbad++;
      end
      if (bus.disp_valid) begin vlat = lat; vpix = bus.disp_pixel; bus.disp_req = 1'b0; end
      if (disp_at > 0 && lat == disp_at) begin
        bus.disp_hpos = 7'(dh); bus.disp_vpos = 6'(dv); bus.disp_req = 1'b1;
      end
      if (bus.cpu_ack) got = 1;
    end
    bus.cpu_req = 1'b0; bus.disp_req = 1'b0;
    chk("clr_ack_lat", lat, (disp_at > 0) ? 8196 : 8193);
    chk("clr_nwe", nwe, VRAM_W * VRAM_H);
    chk("clr_wdata", nbad, 0);
    chk("clr_first", first_a, {7'd0, 6'd0});
    chk("clr_last", last_a, {7'd127, 6'd63});
    chk("clr_col", bus.cpu_collide, 0);
    if (disp_at > 0) begin
      chk("clr_disp_lat", vlat, disp_at + 3);
      chk("clr_disp_pix", vpix, vexp);
    end
    for (int v = 0; v < VRAM_H; v++)
      for (int h = 0; h < VRAM_W; h++) ref_mem[v][h] = 2'b00;
    ref_last_disp = 1'b0;
  endtask

  initial begin
    int n;
    bus.cpu_req = 1'b0; bus.cpu_op = '0; bus.cpu_hpos = '0; bus.cpu_vpos = '0;
    bus.cpu_pixel = '0; bus.disp_req = 1'b0; bus.disp_hpos = '0; bus.disp_vpos = '0;
    for (int v = 0; v < VRAM_H; v++)
      for (int h = 0; h < VRAM_W; h++) ref_mem[v][h] = pat(h, v);

    rst = 1'b1;
    repeat (2) tick;
    mem_init = 1'b0;
    tick;
    chk("rst_ctl", {bus.cpu_ack, bus.cpu_collide, bus.disp_valid, bus.mem_we, bus.busy}, 0);
    chk("rst_data", {bus.cpu_rdata, bus.disp_pixel, bus.mem_wdata}, 0);
    chk("rst_addr", {bus.mem_hpos, bus.mem_vpos}, 0);
    rst = 1'b0;
    ref_last_disp = 1'b1;
    tick;

    // directed write/read/xor sequence
    cpu_do(OP_WR, 5, 3, 2'b10);
    cpu_do(OP_RD, 5, 3, 2'b00);
    cpu_do(OP_XOR, 5, 3, 2'b11);
    cpu_do(OP_WR, 6, 3, 2'b00);
    cpu_do(OP_XOR, 6, 3, 2'b01);
    tick;
    chk("idle_busy", bus.busy, 0);
    chk("ack_pulse", bus.cpu_ack, 0);

    // random single-requester traffic over a small window to force reuse
    repeat (60) begin
      if ($urandom_range(0, 3) == 3)
        disp_do($urandom_range(0, 3), $urandom_range(0, 3));
      else
        cpu_do(2'($urandom_range(0, 2)), $urandom_range(0, 3), $urandom_range(0, 3),
               2'($urandom_range(0, 3)));
    end

    // simultaneous requests with random solo prefixes
    repeat (10) begin
      case ($urandom_range(0, 2))
        1: cpu_do(OP_RD, $urandom_range(0, 127), $urandom_range(0, 63), 2'b00);
        2: disp_do($urandom_range(0, 127), $urandom_range(0, 63));
        default: ;
      endcase
      both_do($urandom_range(0, 127), $urandom_range(0, 63),
              $urandom_range(0, 127), $urandom_range(0, 63));
    end

    // reset in the middle of an xor (cycle G+2)
    bus.cpu_op = OP_XOR; bus.cpu_hpos = 7'd10; bus.cpu_vpos = 6'd10;
    bus.cpu_pixel = 2'b11; bus.cpu_req = 1'b1;
    tick; tick;
    rst = 1'b1;
    tick;
    chk("mid_rst_ctl", {bus.cpu_ack, bus.cpu_collide, bus.disp_valid, bus.mem_we, bus.busy}, 0);
    chk("mid_rst_data", {bus.cpu_rdata, bus.disp_pixel, bus.mem_wdata}, 0);
    chk("mid_rst_addr", {bus.mem_hpos, bus.mem_vpos}, 0);
    rst = 1'b0; bus.cpu_req = 1'b0;
    ref_last_disp = 1'b1;
    n = 0;
    repeat (8) begin
      tick;
      if (bus.cpu_ack || bus.mem_we || bus.busy) n++;
    end
    chk("mid_rst_quiet", n, 0);
    cpu_do(OP_RD, 10, 10, 2'b00);
    both_do(1, 1, 2, 2);

    // clear with one display read in cycle G+100, then random readback
    clear_do(100, $urandom_range(0, 98), 0);
    repeat (8) cpu_do(OP_RD, $urandom_range(0, 127), $urandom_range(0, 63), 2'b00);
    repeat (4) disp_do($urandom_range(0, 127), $urandom_range(0, 63));

    // dirty a few pixels, then an uninterrupted clear
    repeat (6) cpu_do(OP_WR, $urandom_range(0, 127), $urandom_range(0, 63),
                      2'($urandom_range(1, 3)));
    clear_do(0, 0, 0);
    repeat (6) cpu_do(OP_XOR, $urandom_range(0, 127), $urandom_range(0, 63),
                      2'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
